// File: rtl/spi_master_multi_if.sv
// Word-level request/response bus between a client and spi_master_multi.
// master = client side (drives tx words), slave = the SPI engine.
interface spi_master_multi_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  tx_last;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;

  modport master (
    output tx_data, tx_valid, tx_last,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, tx_last,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_master_multi.sv
// SPI master with runtime mode/divider, multiple chip selects and multi-word frames.
// Optional internal MOSI->MISO loop enabled by macro SPI_MASTER_MULTI_LOOPBACK_EN.
module spi_master_multi #(
  parameter  int DATA_WIDTH = 8,
  parameter  int CS_WIDTH   = 4,
  parameter  int DIV_WIDTH  = 8,
  localparam int CS_SEL_W   = $clog2(CS_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic [CS_SEL_W-1:0]  cs_sel,
  input  logic                 loopback,
  spi_master_multi_if.slave    bus,
  output logic                 busy,
  output logic                 sclk,
  output logic [CS_WIDTH-1:0]  cs_n,
  output logic                 mosi,
  input  logic                 miso
);

  localparam int EDGE_W = $clog2(2*DATA_WIDTH + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2*DATA_WIDTH);
  localparam logic [EDGE_W-1:0] PENULT    = EDGE_W'(2*DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, NEXT, DEASSERT} state_e;

  state_e                state_q, state_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [EDGE_W-1:0]     edge_q, edge_d;
  logic                  sclk_q, sclk_d;
  logic [CS_WIDTH-1:0]   cs_n_q, cs_n_d;
  logic                  mosi_q, mosi_d;
  logic                  cpha_q, cpha_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;

  logic                  accept, tick, odd_edge, shift_edge, sample_edge, rx_bit;
  logic [CS_WIDTH-1:0]   cs_dec;

`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
  assign rx_bit = loopback ? mosi_q : miso;
`else
  logic unused_loopback;
  assign unused_loopback = loopback;
  assign rx_bit = miso;
`endif

  assign bus.tx_ready = !rst && (state_q == IDLE || state_q == NEXT);
  assign accept       = bus.tx_valid && bus.tx_ready;
  // Equality compare (not a down-counter) so an all-ones divider gives a full period.
  assign tick         = (cnt_q == div_q);
  // edge_q counts edges already made; the pending edge number is edge_q+1.
  assign odd_edge     = ~edge_q[0];
  assign shift_edge   = cpha_q ? odd_edge : (!odd_edge && edge_q != PENULT);
  assign sample_edge  = cpha_q ? !odd_edge : odd_edge;

  // Out-of-range selects leave every line deasserted.
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < CS_WIDTH; i++)
      if (cs_sel == CS_SEL_W'(i)) cs_dec[i] = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    edge_d     = edge_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    cpha_d     = cpha_q;
    last_d     = last_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        sclk_d = cpol;
        mosi_d = 1'b0;
        cs_n_d = '1;
        if (accept) begin
          cpha_d  = cpha;
          div_d   = clk_div;
          last_d  = bus.tx_last;
          cs_n_d  = cs_dec;
          cnt_d   = '0;
          tx_sh_d = cpha ? bus.tx_data : {bus.tx_data[DATA_WIDTH-2:0], 1'b0};
          mosi_d  = cpha ? 1'b0 : bus.tx_data[DATA_WIDTH-1];
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
        if (tick) begin
          cnt_d   = '0;
          edge_d  = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
        if (tick) begin
          cnt_d = '0;
          if (edge_q == LAST_EDGE) begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_sh_q;
            if (last_q) begin
              cs_n_d  = '1;
              mosi_d  = 1'b0;
              state_d = DEASSERT;
            end else begin
              state_d = NEXT;
            end
          end else begin
            sclk_d = ~sclk_q;
            edge_d = edge_q + EDGE_W'(1);
            if (shift_edge) begin
              mosi_d  = tx_sh_q[DATA_WIDTH-1];
              tx_sh_d = {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
            end
            if (sample_edge) rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], rx_bit};
          end
        end
      end
      NEXT: begin
        // Continuation word: frame settings and CS stay as latched at frame start.
        if (accept) begin
          last_d  = bus.tx_last;
          cnt_d   = '0;
          edge_d  = '0;
          tx_sh_d = cpha_q ? bus.tx_data : {bus.tx_data[DATA_WIDTH-2:0], 1'b0};
          if (!cpha_q) mosi_d = bus.tx_data[DATA_WIDTH-1];
          state_d = XFER;
        end
      end
      DEASSERT: begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
        if (tick) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      edge_q     <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= '1;
      mosi_q     <= 1'b0;
      cpha_q     <= 1'b0;
      last_q     <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      edge_q     <= edge_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      cpha_q     <= cpha_d;
      last_q     <= last_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign sclk         = sclk_q;
  assign cs_n         = cs_n_q;
  assign mosi         = mosi_q;
  assign busy         = (state_q != IDLE);
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule

// File: doc/spi_master_multi.md
SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per word, legal range 2..32.
REQ-002 Parameter CS_WIDTH, default 4: number of chip-select lines, legal range 2..16; CS_SEL_W = clog2(CS_WIDTH).
REQ-003 Parameter DIV_WIDTH, default 8: width of the runtime clock divider.
REQ-004 The ports SHALL be as follows; reset is synchronous and active-high:
- clk  in  1: the single system clock; all logic is on its rising edge.
- rst  in  1: synchronous active-high reset.
- cpol  in  1: clock polarity; latched at frame start.
- cpha  in  1: clock phase; latched at frame start.
- clk_div  in  DIV_WIDTH: SCLK half-period minus 1, in clk cycles; latched at frame start.
- cs_sel  in  CS_SEL_W: index of the slave; latched at frame start.
- tx_data  in  DATA_WIDTH: word to send, MSB first.
- tx_valid  in  1: tx_data, tx_last and the frame fields are valid.
- tx_ready  out  1: the block accepts a word.
- tx_last  in  1: when high, the word ends the frame; when low, CS stays asserted.
- loopback  in  1: internal MOSI-to-MISO loop (see Configuration).
- rx_data  out  DATA_WIDTH: received word.
- rx_valid  out  1: one-cycle pulse; rx_data is valid.
- busy  out  1: high whenever the state is not IDLE.
- sclk  out  1: SPI clock.
- cs_n  out  CS_WIDTH: active-low chip selects.
- mosi  out  1: serial data out.
- miso  in  1: serial data in.

Function
REQ-005 The FSM SHALL have the states IDLE, SETUP, XFER, NEXT and DEASSERT.
REQ-006 Handshake: a word is accepted when tx_valid and tx_ready are both high in the same cycle; tx_ready SHALL be high only in IDLE and NEXT, and never while rst is high.
REQ-007 Accept in IDLE: latch cpol, cpha, clk_div, cs_sel, tx_data and tx_last, then go to SETUP; cs_n[cs_sel] falls in the next cycle.
REQ-008 SETUP SHALL last clk_div+1 cycles, then go to XFER; with CPHA=0, mosi carries the MSB from the first SETUP cycle.
REQ-009 XFER SHALL generate exactly 2*DATA_WIDTH SCLK edges, each clk_div+1 cycles apart; the first edge comes clk_div+1 cycles after XFER entry; sclk ends at the latched CPOL.
REQ-010 CPHA=0: sample miso on the odd edges (1, 3, ...) and shift mosi on the even edges, except the final edge. CPHA=1: shift mosi on the odd edges (the first edge presents the MSB) and sample on the even edges.
REQ-011 XFER SHALL end clk_div+1 cycles after edge 2*DATA_WIDTH; in that cycle rx_valid pulses for one cycle with rx_data holding the received word, MSB first.
REQ-012 At the end of XFER: if the latched tx_last=0, go to NEXT; otherwise go to DEASSERT.
REQ-013 NEXT SHALL hold cs_n and sclk and wait without limit. On accept, latch tx_data and tx_last only (cs_sel, cpol, cpha and clk_div are ignored) and go directly to XFER.
REQ-014 DEASSERT SHALL drive all of cs_n high for clk_div+1 cycles, then go to IDLE; this is the minimum gap between frames.
REQ-015 If cs_sel >= CS_WIDTH, the transfer SHALL still clock, but no cs_n line is asserted.
REQ-016 In IDLE, sclk SHALL follow the registered cpol input, and mosi SHALL be 0.
REQ-017 clk_div=0 SHALL give SCLK = clk/2; clk_div = all ones SHALL count correctly, with no wrap-induced short period.
REQ-018 Changes to cpol, cpha, clk_div or cs_sel during a frame SHALL have no effect.

Reset
REQ-019 On rst: state=IDLE, sclk=0, cs_n=all ones, mosi=0, rx_data=0, rx_valid=0, busy=0 and tx_ready=0, all on the next clk edge. This applies mid-transfer too, with no partial rx_valid.
REQ-020 tx_ready SHALL rise in the first cycle after rst falls.

Configuration
REQ-021 Macro SPI_MASTER_MULTI_LOOPBACK_EN. When defined, loopback=1 makes the sampled bit the internal mosi instead of miso; the pins still toggle. When undefined, the loopback port exists but is ignored, and no loop logic is synthesised.

Verification
REQ-022 DATA_WIDTH=8, cpol=0, cpha=0, clk_div=1, cs_sel=2, tx_data=0xA5, tx_last=1, miso replays 0x3C -> cs_n=4'b1011 during the frame; 16 sclk edges at a 4-cycle period; mosi=10100101; rx_valid pulse with rx_data=0x3C; busy returns low.
REQ-023 Modes 1, 2 and 3 with tx_data=0x81 against a mode-matched slave model -> rx_data equals the slave's 0x7E; idle sclk level equals cpol.
REQ-024 Burst of 0x11 (tx_last=0), 0x22 (0), 0x33 (1) with cs_sel changed to 0 mid-burst -> cs_n[1] stays low throughout; 3 rx_valid pulses; cs_n[0] is never low.
REQ-025 rst asserted at edge 7 of a frame -> the next cycle has cs_n=all ones, sclk=0, no rx_valid; a following frame is correct.
REQ-026 With SPI_MASTER_MULTI_LOOPBACK_EN defined, loopback=1, tx_data=0x5A, miso held at 0 -> rx_data=0x5A; without the macro -> rx_data=0x00.
REQ-027 clk_div=0 and clk_div=255 -> half-periods measure 1 and 256 cycles; tx_ready is low from accept until NEXT or IDLE.
